// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction fetch front end
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REQ_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        addr;
        logic [INSTR_W-1:0] data;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry circular FIFO of tagged fetched words
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   store [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           pop_ok;
    logic           push_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = store[rd_ptr];
    assign pop_ok  = pop && !empty;
    // flush beats push; a push into a full queue is only accepted alongside a pop
    assign push_ok = push && !flush && (!full || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - prefetching instruction fetch front end with redirect on pc discontinuity
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    input  logic               take,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  state, state_nx;
    logic [31:0]   fetch_addr, fetch_nx;
    logic [31:0]   req_addr, req_nx;
    logic [31:0]   expected;
    logic [31:0]   pc_word;
    logic          redirect;
    logic          push, pop, flush;
    fetch_entry_t  head;
    logic [CW-1:0] count;
    logic          full, empty;
    logic [CW:0]   occ_after_ack;
    logic          room_now;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry ({req_addr, mem_rdata}),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign pc_word     = {pc[31:2], 2'b00};
    assign instr_valid = !empty && (head.addr == pc);
    assign instr       = instr_valid ? head.data : '0;
    assign pop         = take && instr_valid;
    assign mem_req     = (state != IDLE);
    assign mem_addr    = req_addr;

    // the address the core should be asking for if no discontinuity happened
    assign expected = !empty ? head.addr : ((state == REQ) ? req_addr : fetch_addr);
    assign redirect = (pc != expected);

    assign occ_after_ack = {1'b0, count} + (CW + 1)'(1) - (CW + 1)'(pop);
    assign room_now      = (({1'b0, count} - (CW + 1)'(pop)) < DEPTH_W);

    always_comb begin
        state_nx = state;
        fetch_nx = fetch_addr;
        req_nx   = req_addr;
        push     = 1'b0;
        flush    = redirect;
        if (redirect) fetch_nx = pc_word;
        case (state)
            IDLE: begin
                if (redirect) begin
                    req_nx   = pc_word;
                    state_nx = REQ;
                end else if (room_now) begin
                    req_nx   = fetch_addr;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (redirect) begin
                        state_nx = IDLE;
                    end else begin
                        push     = 1'b1;
                        fetch_nx = req_addr + PC_STEP;
                        if (occ_after_ack < DEPTH_W) req_nx = req_addr + PC_STEP;
                        else                         state_nx = IDLE;
                    end
                end else if (redirect) begin
                    // the bus request cannot be withdrawn; let it finish and drop the data
                    state_nx = REQ_DROP;
                end
            end
            REQ_DROP: begin
                if (mem_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_addr <= RESET_PC;
            req_addr   <= '0;
        end else begin
            state      <= state_nx;
            fetch_addr <= fetch_nx;
            req_addr   <= req_nx;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        take;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        take;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
    } vec_t;

    vec_t tbl_main[$];
    vec_t tbl_post[$];

    instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .take        (take),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    function automatic vec_t mk(input logic [31:0] p, input logic t, input logic a,
                                input logic r, input logic [31:0] ad, input logic v);
        vec_t x;
        x.pc = p; x.take = t; x.ack = a; x.exp_req = r; x.exp_addr = ad; x.exp_valid = v;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        pc      = v.pc;
        take    = v.take;
        mem_ack = v.ack;
        #1;
        check({tag, " mem_req"},     {31'b0, mem_req},     {31'b0, v.exp_req});
        check({tag, " mem_addr"},    mem_addr,             v.exp_addr);
        check({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, v.exp_valid});
        check({tag, " instr"},       instr,                v.exp_valid ? mem_word(v.pc) : 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // sequential run, delayed ack, full queue, push+pop, jump, take while invalid
        tbl_main.push_back(mk(32'h00, 1, 0, 0, 32'h00, 0));
        tbl_main.push_back(mk(32'h00, 1, 1, 1, 32'h00, 0));
        tbl_main.push_back(mk(32'h00, 1, 1, 1, 32'h04, 1));
        tbl_main.push_back(mk(32'h04, 1, 1, 1, 32'h08, 1));
        tbl_main.push_back(mk(32'h08, 1, 0, 1, 32'h0C, 1));
        tbl_main.push_back(mk(32'h0C, 1, 0, 1, 32'h0C, 0));
        tbl_main.push_back(mk(32'h0C, 1, 0, 1, 32'h0C, 0));
        tbl_main.push_back(mk(32'h0C, 1, 1, 1, 32'h0C, 0));
        tbl_main.push_back(mk(32'h0C, 0, 1, 1, 32'h10, 1));
        tbl_main.push_back(mk(32'h0C, 0, 0, 0, 32'h10, 1));
        tbl_main.push_back(mk(32'h0C, 0, 0, 0, 32'h10, 1));
        tbl_main.push_back(mk(32'h0C, 1, 0, 0, 32'h10, 1));
        tbl_main.push_back(mk(32'h10, 1, 1, 1, 32'h14, 1));
        tbl_main.push_back(mk(32'h14, 0, 0, 1, 32'h18, 1));
        tbl_main.push_back(mk(32'h40, 0, 0, 1, 32'h18, 0));
        tbl_main.push_back(mk(32'h40, 0, 1, 1, 32'h18, 0));
        tbl_main.push_back(mk(32'h40, 0, 0, 0, 32'h18, 0));
        tbl_main.push_back(mk(32'h40, 0, 1, 1, 32'h40, 0));
        tbl_main.push_back(mk(32'h40, 1, 0, 1, 32'h44, 1));
        tbl_main.push_back(mk(32'h44, 1, 0, 1, 32'h44, 0));
        tbl_main.push_back(mk(32'h44, 1, 1, 1, 32'h44, 0));
        tbl_main.push_back(mk(32'h44, 0, 0, 1, 32'h48, 1));
        tbl_main.push_back(mk(32'h44, 1, 0, 1, 32'h48, 1));
        tbl_main.push_back(mk(32'h48, 0, 0, 1, 32'h48, 0));

        // after mid-request reset: first fetch at RESET_PC, then jump with same-cycle ack
        tbl_post.push_back(mk(32'h00, 0, 0, 0, 32'h00, 0));
        tbl_post.push_back(mk(32'h80, 0, 1, 1, 32'h00, 0));
        tbl_post.push_back(mk(32'h80, 0, 0, 0, 32'h00, 0));
        tbl_post.push_back(mk(32'h80, 0, 1, 1, 32'h80, 0));
        tbl_post.push_back(mk(32'h80, 1, 0, 1, 32'h84, 1));
        tbl_post.push_back(mk(32'h84, 0, 0, 1, 32'h84, 0));

        reset   = 1'b0;
        pc      = 32'h0;
        take    = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset mem_req",     {31'b0, mem_req},     32'h0);
        check("reset mem_addr",    mem_addr,             32'h0);
        check("reset instr_valid", {31'b0, instr_valid}, 32'h0);
        check("reset instr",       instr,                32'h0);
        reset = 1'b1;

        foreach (tbl_main[i]) run_vec(tbl_main[i], $sformatf("main[%0d]", i));

        // request for 0x48 still outstanding; pull reset asynchronously
        pc      = 32'h0;
        take    = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("pre-reset mem_req", {31'b0, mem_req}, 32'h1);
        reset = 1'b0;
        #1;
        check("async reset mem_req",     {31'b0, mem_req},     32'h0);
        check("async reset instr_valid", {31'b0, instr_valid}, 32'h0);
        check("async reset mem_addr",    mem_addr,             32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (tbl_post[i]) run_vec(tbl_post[i], $sformatf("post[%0d]", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
